// File: rtl/alu_exec_unit_if.sv
// Execute-stage bundle: operands and control in, result/flags/HI-LO and start/busy/done out.
interface alu_exec_unit_if;
    logic        start;
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, ctrl, a, b, shamt,
        input  result, zero, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, ctrl, a, b, shamt,
        output result, zero, hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU with iterative mult/div into HI/LO; 1-cycle ops, mult/div done 34 cycles after start.
// Stalls via busy: start is ignored while busy, nothing is queued.
module alu_exec_unit (
    input  logic          clk,
    input  logic          reset,
    alu_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] mb;
    logic        sign_a;
    logic        sign_b;
    logic        is_div;
    logic [31:0] result_q;
    logic        zero_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic [31:0] op_res;
    logic        op_zero;
    logic        br;
    logic        br_cond;
    logic        op_mult;
    logic        op_div;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        unused_ctrl_msb;

    assign unused_ctrl_msb = bus.ctrl[5];
    assign op_mult = (bus.ctrl[4:0] == 5'b01000);
    assign op_div  = (bus.ctrl[4:0] == 5'b01010);
    assign a_abs   = bus.a[31] ? 32'(-bus.a) : bus.a;
    assign b_abs   = bus.b[31] ? 32'(-bus.b) : bus.b;

    always_comb begin
        op_res  = '0;
        br      = 1'b0;
        br_cond = 1'b0;
        case (bus.ctrl[4:0])
            5'b00000: op_res = bus.a & bus.b;
            5'b00010: op_res = bus.a | bus.b;
            5'b00110: op_res = bus.a ^ bus.b;
            5'b11000: op_res = ~(bus.a | bus.b);
            5'b00100: op_res = bus.a + bus.b;
            5'b01100: op_res = bus.a - bus.b;
            5'b01110,
            5'b00111: op_res = {31'h0, $signed(bus.a) < $signed(bus.b)};
            5'b10000: op_res = bus.b << bus.shamt;
            5'b10010: op_res = bus.b >> bus.shamt;
            5'b10100: op_res = $signed(bus.b) >>> bus.shamt;
            5'b10110: op_res = bus.b << bus.a[4:0];
            5'b00011: op_res = {bus.b[15:0], 16'h0};
            5'b01111: op_res = hi_q;
            5'b00001: op_res = lo_q;
            5'b11010: begin br = 1'b1; br_cond = (bus.a != bus.b);       end
            5'b11100: begin br = 1'b1; br_cond = ($signed(bus.a) <= 0);  end
            5'b11110: begin br = 1'b1; br_cond = ($signed(bus.a) > 0);   end
            default:  op_res = '0;
        endcase
        op_zero = br ? br_cond : (op_res == 32'h0);
    end

    // Shift-add: multiplier sits in acc[31:0], partial product grows in acc[63:32].
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mb} : 33'h0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring divide: remainder in acc[63:32], dividend shifts out of acc[31:0] as quotient shifts in.
    logic [32:0] div_rs;
    logic [31:0] div_diff;
    logic        div_borrow;
    logic [63:0] div_next;
    assign div_rs     = {acc[63:32], acc[31]};
    assign div_diff   = div_rs[31:0] - mb;
    assign div_borrow = (div_rs < {1'b0, mb});
    assign div_next   = div_borrow ? {div_rs[31:0], acc[30:0], 1'b0}
                                   : {div_diff,     acc[30:0], 1'b1};

    logic [63:0] fix_val;
    always_comb begin
        if (is_div) begin
            fix_val[31:0]  = (sign_a ^ sign_b) ? 32'(-acc[31:0]) : acc[31:0];
            fix_val[63:32] = sign_a ? 32'(-acc[63:32]) : acc[63:32];
        end else begin
            fix_val = (sign_a ^ sign_b) ? 64'(-acc) : acc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mb       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (op_div && bus.b == 32'h0) begin
                            done_q   <= 1'b1;
                            dbz_q    <= 1'b1;
                            result_q <= lo_q;
                            zero_q   <= (lo_q == 32'h0);
                        end else if (op_mult || op_div) begin
                            sign_a <= bus.a[31];
                            sign_b <= bus.b[31];
                            is_div <= op_div;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            acc    <= {32'h0, op_div ? a_abs : b_abs};
                            mb     <= op_div ? b_abs : a_abs;
                            state  <= op_div ? DIV : MUL;
                        end else begin
                            result_q <= op_res;
                            zero_q   <= op_zero;
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= (state == DIV) ? div_next : mul_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= FIX;
                end
                FIX: begin
                    hi_q     <= fix_val[63:32];
                    lo_q     <= fix_val[31:0];
                    result_q <= fix_val[31:0];
                    zero_q   <= (fix_val[31:0] == 32'h0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execution unit that consumes the 6-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Single-cycle operations complete in one clock; `mult`/`div` run as an iterative 32-step sequence that writes the HI/LO register pair, which `mfhi`/`mflo` then read. The unit sits in the execute stage, driven by the decoder output and the register-file read ports. A start/busy/done handshake stalls the pipeline.

## Interface
- No parameters; data width fixed at 32, shift amount at 5.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request; sampled only when `busy`=0.
- `ctrl` in 6: ALU control code; bit 5 ignored, bits [4:0] decoded.
- `a` in 32: operand A (rs).
- `b` in 32: operand B (rt or sign-extended immediate).
- `shamt` in 5: shift amount for sll/srl/sra.
- `result` out 32: registered result.
- `zero` out 1: registered flag.
- `hi`, `lo` out 32 each: HI/LO registers.
- `busy` out 1: a multi-cycle op is in progress.
- `done` out 1: one-cycle pulse marking a valid `result`.
- `div_by_zero` out 1: pulses with `done` on a div with `b`=0.

## Operation
- Codes, ctrl[4:0]:
  - 00000 and; 00010 or; 00110 xor; 11000 nor.
  - 00100 add; 01100 sub (also beq); 01110 slt, signed; 00111 slti, signed, same as slt.
  - 10000 sll; 10010 srl; 10100 sra: each shifts `b` by `shamt`.
  - 10110 sllv: shifts `b` by `a[4:0]`.
  - 00011 lui: result = {b[15:0],16'h0}.
  - 01111 mfhi: result = `hi`. 00001 mflo: result = `lo`.
  - 11010 bne; 11100 blez; 11110 bgtz.
  - 01000 mult; 01010 div.
  - Any other code: result=0, zero=1, `done` still pulses.
- Arithmetic:
  - add/sub wrap mod 2^32; no overflow trap.
  - Code 11000 always executes nor.
- `zero` flag:
  - Equals (result==0) for every op except branches.
  - Branches force result=0 and set `zero` to the branch condition: bne a!=b; blez $signed(a)<=0; bgtz $signed(a)>0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: `start` with a single-cycle code registers result/zero and pulses `done`; stays in IDLE.
  - IDLE with mult/div: latch |a| and |b| as 32-bit unsigned, plus the signs; clear the 6-bit counter; go to MUL or DIV.
  - MUL: shift-add one bit per cycle, 64-bit product.
  - DIV: restoring divide one bit per cycle, quotient plus remainder.
  - MUL/DIV exit to FIX after 32 iterations.
  - FIX: apply signs, write hi/lo, result=lo, pulse `done`, return to IDLE.
- mult: {hi,lo} = signed 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- div with `b`=0:
  - Detected in IDLE; no iteration.
  - Next cycle: `done`=1, `div_by_zero`=1, result=lo, hi/lo unchanged.
- `start` while `busy`=1 is ignored; no queuing.
- `a`/`b` need only be valid in the start cycle.
- mfhi/mflo issued on the cycle after a mult/div `done` see the new hi/lo.

## Timing
- Reset values: result=0, zero=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0; FSM=IDLE, counter=0.
- Reset mid-operation aborts immediately; hi/lo are cleared.
- Single-cycle op:
  - `start` sampled at edge E0.
  - result/zero valid and `done`=1 during the cycle after E0.
- mult/div:
  - `start` at E0; `busy`=1 after E0.
  - Iterations run on E1..E32; FIX occurs at E33.
  - After E33: `done`=1 and `busy`=0 together, giving 34-cycle latency.
  - A new `start` is accepted at E34.
- div-by-zero: latency 1, `busy` never asserts.
- `done` and `div_by_zero` last exactly one cycle.
- `result` holds its value until the next `done`.

## Test plan
- Reset, then add a=5, b=7 → next cycle result=12, zero=0, done=1; sub a=b=9 → result=0, zero=1.
- sra b=0x80000000, shamt=4 → result=0xF8000000; sllv a=3, b=1 → 8; lui b=0x1234 → 0x12340000.
- mult a=-3 (0xFFFFFFFD), b=7 → done 34 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for 33 cycles; following mfhi returns 0xFFFFFFFF.
- div a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000, b=-1 → lo=0x80000000, hi=0; div b=0 → done+div_by_zero next cycle, hi/lo unchanged.
- bne a=1, b=1 → zero=0; blez a=0 → zero=1; bgtz a=0xFFFFFFFF → zero=0; `start` pulsed during mult busy → ignored, mult result correct.
- Assert `reset` at iteration 10 of a div → all outputs 0 asynchronously; next mult after release completes normally in 34 cycles.
